mem_stage: RTL
==============

Name: mem_stage

Overview:
Memory-access stage of the 8-bit RISC pipeline. It sits between execute and writeback and owns the data memory. It performs byte loads and stores, then registers the ALU result, load data, MOV operand and effective address, along with the writeback control. These registered values form the MEM/WB pipeline register, which directly drives the writeback mux inputs IALUD, IDM, IMOV, Iea2 and WBCR.

Parameters:
DW, 8, datapath width in bits
AW, 8, data-memory address width; depth = 2**AW bytes
RW, 3, register-file address width

Ports:
clk  in  1  stage clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ex_valid  in  1  EX/MEM holds a valid instruction this cycle
ALUD  in  DW  ALU result from execute
EA  in  AW  effective address for load/store
MOVD  in  DW  MOV source operand
STD  in  DW  store data
MEMCR  in  2  00 none, 01 load, 10 store, 11 reserved
WBCR_in  in  2  writeback select, passed through
RD_in  in  RW  destination register
RWE_in  in  1  register write enable
mem_busy  out  1  combinational stall to upstream; hold EX/MEM inputs
IALUD  out  DW  registered ALU result
IDM  out  DW  registered load data
IMOV  out  DW  registered MOV operand
Iea2  out  DW  registered effective address, zero-extended to DW
WBCR  out  2  registered writeback select
wb_rd  out  RW  registered destination register
wb_we  out  1  registered write enable, qualified by wb_valid
wb_valid  out  1  MEM/WB register holds a new instruction (1-cycle pulse)
cr_err  out  1  sticky reserved-MEMCR flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All registered outputs 0; cr_err 0.
  - FSM goes to IDLE.
  - Data memory contents are not reset.
- Data memory:
  - Internal array of 2**AW x DW.
  - Synchronous write; synchronous read with 1-cycle latency; one access per cycle.
- FSM states: IDLE, RD_WAIT.
- IDLE, ex_valid=1, MEMCR=01 (load):
  - Read at EA issues this cycle and mem_busy=1 (combinational).
  - Next edge: go to RD_WAIT and latch ALUD, MOVD, EA, WBCR_in, RD_in, RWE_in into holding regs.
  - wb_valid stays 0 at this edge.
- RD_WAIT:
  - mem_busy=0.
  - Next edge: IDM <= RAM output; other outputs <= holding regs; wb_valid=1; wb_we=RWE; return to IDLE.
  - EX inputs are ignored in this state.
- IDLE, ex_valid=1, MEMCR=10 (store):
  - mem[EA] <= STD at the edge.
  - wb_valid=1 next cycle; wb_we forced 0; IDM holds its previous value.
- IDLE, ex_valid=1, MEMCR=00:
  - Outputs register the same cycle.
  - wb_valid=1 next cycle; IDM holds.
- MEMCR=11: treated as 00 (no memory access) and sets cr_err, which stays set until reset.
- ex_valid=0 (bubble):
  - wb_valid=0, wb_we=0.
  - Data outputs and WBCR hold their last values.
- Latency: non-load 1 cycle; load 2 cycles, with exactly one mem_busy cycle.
- Throughput:
  - One instruction per cycle except loads.
  - Back-to-back loads: busy, wait, busy, wait.
- Store to address A followed by a load from A on the next accepted cycle returns the new data. No bypass is needed because the accesses occur in different cycles.
- wb_we never asserts without wb_valid.
- Reset mid-load: the load is abandoned, FSM goes to IDLE, wb_valid=0, and no writeback pulse follows.
- EA is AW bits; Iea2 zero-extends it to DW when DW > AW.

Decomposition:
- Shared package cpu_pkg holds:
  - MEMCR encodings: MEM_NONE, MEM_LD, MEM_ST, MEM_RSV.
  - WBCR encodings shared with writeback: WB_ALU, WB_DM, WB_MOV, WB_EA.
  - DW and RW defaults.
- One sub-module: data_mem, a single-port synchronous RAM with parameters DW and AW, write enable, and registered read.

Test Plan:
- Reset, ALU path:
  - Stimulus: hold rst_n=0, check all outputs are 0. Release, then drive ex_valid=1, MEMCR=00, ALUD=0x11, WBCR_in=00, RD_in=3, RWE_in=1.
  - Response: next cycle IALUD=0x11, wb_rd=3, wb_we=1, wb_valid=1, mem_busy=0.
- Store then load:
  - Stimulus: store STD=0xA5 to EA=0x40; next cycle load EA=0x40 with WBCR_in=01.
  - Response: store gives wb_we=0; load gives mem_busy=1 for 1 cycle, then IDM=0xA5, wb_valid=1, Iea2=0x40.
- Back-to-back loads:
  - Stimulus: preload mem[0x01]=0x22 and mem[0x02]=0x33; issue loads held per mem_busy.
  - Response: mem_busy pattern 1,0,1,0; IDM 0x22 then 0x33; wb_valid pulses exactly twice.
- Bubble:
  - Stimulus: ex_valid=0 for 3 cycles after the ALU op.
  - Response: wb_valid=0, wb_we=0; IALUD holds 0x11.
- Reserved MEMCR:
  - Stimulus: MEMCR=11.
  - Response: no memory write (mem[EA] unchanged); cr_err=1 and stays 1 until rst_n=0.
- Reset mid-load:
  - Stimulus: assert rst_n=0 while in RD_WAIT.
  - Response: outputs 0 immediately; no wb_valid pulse after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the memory-access stage and the stages around it.
package cpu_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 8;
    localparam int RW_DEF = 3;

    // Memory operation requested by execute.
    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_LD   = 2'b01,
        MEM_ST   = 2'b10,
        MEM_RSV  = 2'b11
    } memcr_e;

    // Writeback mux select; the writeback stage decodes the same values.
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_DM  = 2'b01,
        WB_MOV = 2'b10,
        WB_EA  = 2'b11
    } wbcr_e;

    // Memory stage controller state.
    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory-access stage.
// Handshake: the EX/MEM register presents an instruction whenever ex_valid=1.
// A cycle with ex_valid=1 and mem_busy=0 consumes the instruction. While
// mem_busy=1, upstream must hold every EX/MEM input stable for one more cycle.
// Downstream sees a new instruction exactly on cycles where wb_valid=1.
interface mem_stage_if
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int RW = RW_DEF
);
    logic          ex_valid;
    logic [DW-1:0] ALUD;
    logic [AW-1:0] EA;
    logic [DW-1:0] MOVD;
    logic [DW-1:0] STD;
    logic [1:0]    MEMCR;
    logic [1:0]    WBCR_in;
    logic [RW-1:0] RD_in;
    logic          RWE_in;

    logic          mem_busy;
    logic [DW-1:0] IALUD;
    logic [DW-1:0] IDM;
    logic [DW-1:0] IMOV;
    logic [DW-1:0] Iea2;
    logic [1:0]    WBCR;
    logic [RW-1:0] wb_rd;
    logic          wb_we;
    logic          wb_valid;
    logic          cr_err;

    // Execute/writeback side.
    modport master (
        output ex_valid, ALUD, EA, MOVD, STD, MEMCR, WBCR_in, RD_in, RWE_in,
        input  mem_busy, IALUD, IDM, IMOV, Iea2, WBCR, wb_rd, wb_we, wb_valid, cr_err
    );

    // Memory stage side.
    modport slave (
        input  ex_valid, ALUD, EA, MOVD, STD, MEMCR, WBCR_in, RD_in, RWE_in,
        output mem_busy, IALUD, IDM, IMOV, Iea2, WBCR, wb_rd, wb_we, wb_valid, cr_err
    );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Single-port data memory: synchronous write, registered read, contents not reset.
module data_mem #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // One access per cycle: write when i_we, otherwise a read landing next cycle.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte loads/stores and the MEM/WB pipeline register.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_stage_if.slave   bus,
    output mem_state_e   o_state
);

    mem_state_e    r_state;
    mem_state_e    w_next;
    memcr_e        w_cr;
    logic          w_ld;
    logic          w_pass;
    logic          w_st;
    logic          w_rsv;
    logic          w_mem_en;
    logic          w_mem_we;
    logic          w_busy;
    logic [DW-1:0] w_rdata;
    logic [DW-1:0] w_ea_ext;

    // Load holding registers, filled on the issue edge and drained from RD_WAIT.
    logic [DW-1:0] r_h_alud;
    logic [DW-1:0] r_h_movd;
    logic [DW-1:0] r_h_ea;
    logic [1:0]    r_h_wbcr;
    logic [RW-1:0] r_h_rd;
    logic          r_h_rwe;

    // MEM/WB register.
    logic [DW-1:0] r_ialud;
    logic [DW-1:0] r_idm;
    logic [DW-1:0] r_imov;
    logic [DW-1:0] r_iea2;
    logic [1:0]    r_wbcr;
    logic [RW-1:0] r_wb_rd;
    logic          r_wb_we;
    logic          r_wb_valid;
    logic          r_cr_err;

    assign w_cr     = memcr_e'(bus.MEMCR);
    assign w_ea_ext = DW'(bus.EA);

    data_mem #(.DW(DW), .AW(AW)) u_data_mem (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (bus.EA),
        .i_wdata (bus.STD),
        .o_rdata (w_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-cycle control; RD_WAIT ignores the EX inputs entirely.
    always_comb begin
        w_next   = r_state;
        w_ld     = 1'b0;
        w_pass   = 1'b0;
        w_st     = 1'b0;
        w_rsv    = 1'b0;
        w_mem_en = 1'b0;
        w_mem_we = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ex_valid) begin
                    case (w_cr)
                        MEM_LD: begin
                            w_ld     = 1'b1;
                            w_busy   = 1'b1;
                            w_mem_en = 1'b1;
                            w_next   = RD_WAIT;
                        end
                        MEM_ST: begin
                            w_pass   = 1'b1;
                            w_st     = 1'b1;
                            w_mem_en = 1'b1;
                            w_mem_we = 1'b1;
                        end
                        MEM_RSV: begin
                            w_pass = 1'b1;
                            w_rsv  = 1'b1;
                        end
                        default: begin
                            w_pass = 1'b1;
                        end
                    endcase
                end
            end
            RD_WAIT: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Capture the load's side-band fields while the RAM read is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_alud <= '0;
            r_h_movd <= '0;
            r_h_ea   <= '0;
            r_h_wbcr <= '0;
            r_h_rd   <= '0;
            r_h_rwe  <= 1'b0;
        end else if (w_ld) begin
            r_h_alud <= bus.ALUD;
            r_h_movd <= bus.MOVD;
            r_h_ea   <= w_ea_ext;
            r_h_wbcr <= bus.WBCR_in;
            r_h_rd   <= bus.RD_in;
            r_h_rwe  <= bus.RWE_in;
        end
    end

    // MEM/WB register: non-loads register directly, loads complete from RD_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ialud    <= '0;
            r_idm      <= '0;
            r_imov     <= '0;
            r_iea2     <= '0;
            r_wbcr     <= '0;
            r_wb_rd    <= '0;
            r_wb_we    <= 1'b0;
            r_wb_valid <= 1'b0;
        end else if (r_state == RD_WAIT) begin
            r_ialud    <= r_h_alud;
            r_idm      <= w_rdata;
            r_imov     <= r_h_movd;
            r_iea2     <= r_h_ea;
            r_wbcr     <= r_h_wbcr;
            r_wb_rd    <= r_h_rd;
            r_wb_we    <= r_h_rwe;
            r_wb_valid <= 1'b1;
        end else if (w_pass) begin
            r_ialud    <= bus.ALUD;
            r_imov     <= bus.MOVD;
            r_iea2     <= w_ea_ext;
            r_wbcr     <= bus.WBCR_in;
            r_wb_rd    <= bus.RD_in;
            r_wb_we    <= bus.RWE_in & ~w_st;
            r_wb_valid <= 1'b1;
        end else begin
            r_wb_we    <= 1'b0;
            r_wb_valid <= 1'b0;
        end
    end

    // Sticky flag for the reserved memory-control encoding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cr_err <= 1'b0;
        end else if (w_rsv) begin
            r_cr_err <= 1'b1;
        end
    end

    assign bus.mem_busy = w_busy;
    assign bus.IALUD    = r_ialud;
    assign bus.IDM      = r_idm;
    assign bus.IMOV     = r_imov;
    assign bus.Iea2     = r_iea2;
    assign bus.WBCR     = r_wbcr;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.wb_we    = r_wb_we;
    assign bus.wb_valid = r_wb_valid;
    assign bus.cr_err   = r_cr_err;
    assign o_state      = r_state;

endmodule
